vector_hazard_unit: RTL
=======================

VECTOR_HAZARD_UNIT -- requirements
Module: vector_hazard_unit

Interface
REQ-001 Parameter DATA_W, default 32, the operand/result width in bits.
REQ-002 Parameter REG_AW, default 4, the register address width.
REQ-003 Parameter N_SRC, default 3, the number of source operands resolved per cycle.
REQ-004 Parameter LOAD_LAT, default 2, the cycles (1..15) from a load leaving EX until its data is valid on mem_res.
REQ-005 The block SHALL have one clock; reset is synchronous and active-high; the ports are named clk and rst.
REQ-006 clk  input  1  the clock.
REQ-007 rst  input  1  the synchronous active-high reset.
REQ-008 src_addr  input  N_SRC*REG_AW  the decode-stage source register per operand, with operand i at slice i.
REQ-009 src_data  input  N_SRC*DATA_W  the register-file read data per operand.
REQ-010 src_use  input  N_SRC  a mask of the operands the instruction actually reads.
REQ-011 ex_dest  input  REG_AW, and ex_wr_en  input  1, the EX-stage destination and its write enable.
REQ-012 ex_is_load  input  1  high when the EX instruction is a load.
REQ-013 ex_res  input  DATA_W  the EX result.
REQ-014 mem_dest  input  REG_AW, mem_wr_en  input  1, and mem_res  input  DATA_W, the writeback-side destination, enable and result.
REQ-015 fwd_data  output  N_SRC*DATA_W  the resolved operands.
REQ-016 fwd_sel  output  2*N_SRC  the source per operand: 0 = regfile, 1 = EX, 2 = MEM.
REQ-017 stall  output  1  freezes decode and inserts an EX bubble.
REQ-018 stall_cnt  output  16  a saturating count of stall cycles.

Function
REQ-019 Register 0 SHALL never be forwarded or cause a stall.
REQ-020 Each operand i with src_use[i]=1 SHALL take EX when ex_wr_en=1, ex_is_load=0 and ex_dest matches; otherwise MEM when mem_wr_en=1 and mem_dest matches; otherwise regfile.
REQ-021 EX SHALL take priority over MEM as the younger producer.
REQ-022 When src_use[i]=0, fwd_sel[i] SHALL be 0 and fwd_data[i] SHALL equal src_data[i].
REQ-023 Forwarding SHALL be combinational, with zero latency.
REQ-024 The pending-load FSM SHALL have the states IDLE and BUSY, with registers pend_dest (REG_AW) and cnt (4 bits).
REQ-025 IDLE SHALL go to BUSY when stall=0, ex_wr_en=1, ex_is_load=1 and ex_dest!=0, loading pend_dest<=ex_dest and cnt<=LOAD_LAT-1.
REQ-026 In BUSY, cnt SHALL decrement each cycle while nonzero.
REQ-027 In BUSY with cnt=0, the FSM SHALL go to IDLE, or SHALL reload per REQ-025 when a new qualifying load is in EX in the same cycle.
REQ-028 hazard_ex SHALL be true when any used operand matches ex_dest with ex_wr_en=1 and ex_is_load=1.
REQ-029 hazard_pend SHALL be true when the state is BUSY, cnt!=0, and any used operand matches pend_dest.
REQ-030 stall SHALL equal hazard_ex OR hazard_pend, combinational from registered state.
REQ-031 The load producer SHALL present valid data on mem_res/mem_dest in the cycle cnt reaches 0.
REQ-032 With LOAD_LAT=1, a dependent instruction stalls exactly one cycle.
REQ-033 With LOAD_LAT=N, a dependent instruction stalls exactly N cycles.
REQ-034 stall_cnt SHALL increment on every stall cycle and SHALL saturate at 16'hFFFF.

Reset
REQ-035 While rst=1 at a clk edge: state<=IDLE, cnt<=0, pend_dest<=0, stall_cnt<=0.
REQ-036 While rst=1: stall SHALL be forced to 0, fwd_sel to 0 and fwd_data to src_data.
REQ-037 A reset during BUSY SHALL abandon the pending load, with no stall in the next cycle.

Structure
REQ-038 The shared package SHALL hold the fwd_sel encoding enum (FWD_RF, FWD_EX, FWD_MEM) and the FSM state enum.
REQ-039 A sub-module operand_fwd_mux SHALL be instantiated N_SRC times to compare addresses and select data per operand.
REQ-040 The FSM, the counters and the stall OR SHALL live in the top module.

Verification
REQ-041 Operand 1: src_addr=5, src_use=1, ex_dest=5, ex_wr_en=1, ex_is_load=0, ex_res=32'hAAAA0001, mem_dest=5, mem_res=32'h0000BBBB -> fwd_data[1]=32'hAAAA0001, fwd_sel[1]=1, stall=0.
REQ-042 src_addr=0 with ex_dest=0 and mem_dest=0 both enabled -> fwd_data=src_data, fwd_sel=0.
REQ-043 LOAD_LAT=2; load to r3 in EX with a dependent reader of r3 -> stall=1 for 2 cycles; r3 forwarded from MEM on the third cycle; stall_cnt=2.
REQ-044 A load to r7 enters, then an independent instruction reads r2 -> stall=0 throughout; FSM reaches BUSY then IDLE after LOAD_LAT cycles.
REQ-045 rst asserted during BUSY with cnt=1 -> in the next cycle state=IDLE, stall=0, stall_cnt=0.
REQ-046 Force 65540 consecutive stall cycles -> stall_cnt holds at 16'hFFFF.

Source files
------------

// File: rtl/vector_hazard_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vector_hazard_unit_pkg
// Description : Shared types for the vector hazard unit: operand source
//               select encoding, pending-load FSM states and common widths.
// Revision    : 1.0 - initial release
// ============================================================================
package vector_hazard_unit_pkg;

    // Operand source select, as presented on fwd_sel.
    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2
    } fwd_sel_e;

    // Pending-load tracker states.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } hz_state_e;

    localparam int c_FWD_SEL_W   = 2;
    localparam int c_CNT_W       = 4;
    localparam int c_STALL_CNT_W = 16;

endpackage
`default_nettype wire

// File: rtl/vector_hazard_unit_fwd_mux.sv
`default_nettype none
// ============================================================================
// Module      : operand_fwd_mux
// Description : Per-operand address compare and forwarding select. Picks the
//               EX result (non-load producer) over the MEM/writeback result
//               over the register file, and reports load-use matches against
//               the EX load and the pending load.
// Ports       : src_addr/src_data/src_use - one decode operand
//               ex_* / mem_*               - producer destinations and data
//               pend_dest/pend_valid       - load still waiting for its data
//               fwd_data/fwd_sel           - resolved operand and its source
//               load_hit/pend_hit          - load-use hazard flags
// Revision    : 1.0 - initial release
// ============================================================================
module operand_fwd_mux
    import vector_hazard_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4
) (
    input  logic [REG_AW-1:0] src_addr,
    input  logic [DATA_W-1:0] src_data,
    input  logic              src_use,
    input  logic [REG_AW-1:0] ex_dest,
    input  logic              ex_wr_en,
    input  logic              ex_is_load,
    input  logic [DATA_W-1:0] ex_res,
    input  logic [REG_AW-1:0] mem_dest,
    input  logic              mem_wr_en,
    input  logic [DATA_W-1:0] mem_res,
    input  logic [REG_AW-1:0] pend_dest,
    input  logic              pend_valid,
    output logic [DATA_W-1:0] fwd_data,
    output fwd_sel_e          fwd_sel,
    output logic              load_hit,
    output logic              pend_hit
);

    logic w_live;
    logic w_ex_match;
    logic w_mem_match;

    // Register 0 is hardwired, so it never matches any producer.
    assign w_live      = src_use && (src_addr != '0);
    assign w_ex_match  = w_live && ex_wr_en  && (ex_dest  == src_addr);
    assign w_mem_match = w_live && mem_wr_en && (mem_dest == src_addr);

    // A load in EX has no data yet; it can only raise a hazard, so an older
    // MEM producer of the same register is still the best available source.
    always_comb begin
        fwd_sel  = FWD_RF;
        fwd_data = src_data;
        if (w_ex_match && !ex_is_load) begin
            fwd_sel  = FWD_EX;
            fwd_data = ex_res;
        end else if (w_mem_match) begin
            fwd_sel  = FWD_MEM;
            fwd_data = mem_res;
        end
    end

    assign load_hit = w_ex_match && ex_is_load;
    assign pend_hit = w_live && pend_valid && (pend_dest == src_addr);

endmodule
`default_nettype wire

// File: rtl/vector_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : vector_hazard_unit
// Description : Operand forwarding and load-use stall generation for N_SRC
//               decode operands. Forwarding is purely combinational; a small
//               FSM tracks one load in flight until its data reaches mem_res.
// Ports       : clk, rst                  - clock, sync active-high reset
//               src_addr/src_data/src_use - decode operands (slice i = op i)
//               ex_dest/ex_wr_en/ex_is_load/ex_res - EX-stage producer
//               mem_dest/mem_wr_en/mem_res         - writeback-side producer
//               fwd_data/fwd_sel          - resolved operands and sources
//               stall                     - freeze decode, bubble into EX
//               stall_cnt                 - saturating stall-cycle count
// Revision    : 1.0 - initial release
// ============================================================================
module vector_hazard_unit
    import vector_hazard_unit_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 4,
    parameter int N_SRC    = 3,
    parameter int LOAD_LAT = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_SRC*REG_AW-1:0]   src_addr,
    input  logic [N_SRC*DATA_W-1:0]   src_data,
    input  logic [N_SRC-1:0]          src_use,
    input  logic [REG_AW-1:0]         ex_dest,
    input  logic                      ex_wr_en,
    input  logic                      ex_is_load,
    input  logic [DATA_W-1:0]         ex_res,
    input  logic [REG_AW-1:0]         mem_dest,
    input  logic                      mem_wr_en,
    input  logic [DATA_W-1:0]         mem_res,
    output logic [N_SRC*DATA_W-1:0]   fwd_data,
    output logic [2*N_SRC-1:0]        fwd_sel,
    output logic                      stall,
    output logic [15:0]               stall_cnt
);

    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(LOAD_LAT - 1);

    hz_state_e                r_state;
    hz_state_e                w_state_nxt;
    logic [REG_AW-1:0]        r_pend_dest;
    logic [REG_AW-1:0]        w_pend_dest_nxt;
    logic [c_CNT_W-1:0]       r_cnt;
    logic [c_CNT_W-1:0]       w_cnt_nxt;
    logic [c_STALL_CNT_W-1:0] r_stall_cnt;
    logic [c_STALL_CNT_W-1:0] w_stall_cnt_nxt;

    logic [DATA_W-1:0] w_mux_data [N_SRC];
    fwd_sel_e          w_mux_sel  [N_SRC];
    logic [N_SRC-1:0]  w_load_hit;
    logic [N_SRC-1:0]  w_pend_hit;

    logic w_pend_valid;
    logic w_hazard_ex;
    logic w_hazard_pend;
    logic w_load_start;

    // The pending load only blocks readers while its data is still on the
    // way; on the cycle cnt reaches 0 the data is on mem_res and forwards.
    assign w_pend_valid = (r_state == ST_BUSY) && (r_cnt != '0);

    generate
        for (genvar i = 0; i < N_SRC; i++) begin : g_operand
            operand_fwd_mux #(
                .DATA_W (DATA_W),
                .REG_AW (REG_AW)
            ) u_mux (
                .src_addr   (src_addr[i*REG_AW +: REG_AW]),
                .src_data   (src_data[i*DATA_W +: DATA_W]),
                .src_use    (src_use[i]),
                .ex_dest    (ex_dest),
                .ex_wr_en   (ex_wr_en),
                .ex_is_load (ex_is_load),
                .ex_res     (ex_res),
                .mem_dest   (mem_dest),
                .mem_wr_en  (mem_wr_en),
                .mem_res    (mem_res),
                .pend_dest  (r_pend_dest),
                .pend_valid (w_pend_valid),
                .fwd_data   (w_mux_data[i]),
                .fwd_sel    (w_mux_sel[i]),
                .load_hit   (w_load_hit[i]),
                .pend_hit   (w_pend_hit[i])
            );

            assign fwd_data[i*DATA_W +: DATA_W] = rst ? src_data[i*DATA_W +: DATA_W]
                                                      : w_mux_data[i];
            assign fwd_sel[i*2 +: 2]            = rst ? FWD_RF : w_mux_sel[i];
        end
    endgenerate

    assign w_hazard_ex   = |w_load_hit;
    assign w_hazard_pend = |w_pend_hit;
    assign stall         = !rst && (w_hazard_ex || w_hazard_pend);
    assign stall_cnt     = r_stall_cnt;

    // A load in EX always moves on, even when decode stalls on that very
    // load, so the EX-load hazard must not block its capture. Only the
    // pending-load stall gates capture: the tracker holds a single load.
    assign w_load_start = ex_wr_en && ex_is_load && (ex_dest != '0) && !w_hazard_pend;

    always_comb begin
        w_state_nxt     = r_state;
        w_pend_dest_nxt = r_pend_dest;
        w_cnt_nxt       = r_cnt;
        w_stall_cnt_nxt = r_stall_cnt;

        if (stall && (r_stall_cnt != '1)) begin
            w_stall_cnt_nxt = r_stall_cnt + 16'd1;
        end

        case (r_state)
            ST_IDLE: begin
                if (w_load_start) begin
                    w_state_nxt     = ST_BUSY;
                    w_pend_dest_nxt = ex_dest;
                    w_cnt_nxt       = c_CNT_INIT;
                end
            end
            ST_BUSY: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else if (w_load_start) begin
                    w_pend_dest_nxt = ex_dest;
                    w_cnt_nxt       = c_CNT_INIT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_pend_dest <= '0;
            r_cnt       <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pend_dest <= w_pend_dest_nxt;
            r_cnt       <= w_cnt_nxt;
            r_stall_cnt <= w_stall_cnt_nxt;
        end
    end

endmodule
`default_nettype wire
